// File: rtl/idli_sqi_mem_rsp_if.sv
// SQI bus between the core (initiator) and a nibble-plane memory responder.
// Signal names are from the responder's point of view.
interface idli_sqi_mem_rsp_if;
    typedef logic [3:0] sqi_data_t;

    logic      i_sqi_cs_n;
    sqi_data_t i_sqi_sio;
    sqi_data_t o_sqi_sio;
    logic      o_sqi_sio_en;

    modport master (
        output i_sqi_cs_n,
        output i_sqi_sio,
        input  o_sqi_sio,
        input  o_sqi_sio_en
    );

    modport slave (
        input  i_sqi_cs_n,
        input  i_sqi_sio,
        output o_sqi_sio,
        output o_sqi_sio_en
    );
endinterface

// File: rtl/idli_sqi_mem_rsp.sv
// SQI memory responder: decodes 4b command/address/data streams and serves
// sequential reads and writes from an on-chip byte array.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | CS high, bus not driven
// ST_CMD     | command nibble 0 held, nibble 1 arriving
// ST_ADDR    | six address nibbles, MSB first
// ST_DUMMY   | two ignored nibbles; last one preloads the first read nibble
// ST_RD_DATA | driving data, high nibble then low nibble per byte
// ST_WR_DATA | receiving data, byte written when its low nibble arrives
// ST_IGNORE  | unknown command, silent until CS deasserts
module idli_sqi_mem_rsp #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    idli_sqi_mem_rsp_if.slave sqi
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    state_t            r_state,   w_state_nxt;
    logic [2:0]        r_cnt,     w_cnt_nxt;
    logic [3:0]        r_cmd_hi,  w_cmd_hi_nxt;
    logic              r_is_wr,   w_is_wr_nxt;
    logic              r_phase,   w_phase_nxt;
    logic [3:0]        r_wr_hi,   w_wr_hi_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [3:0]        r_sio,     w_sio_nxt;
    logic              r_sio_en,  w_sio_en_nxt;

    logic [ADDR_W-1:0] w_addr_shift;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [7:0]        w_cmd;
    logic [7:0]        w_rd_byte;
    logic              w_mem_we;
    logic [7:0]        w_mem_wdata;

    logic [7:0]        r_mem [MEM_BYTES];

    assign w_cmd      = {r_cmd_hi, sqi.i_sqi_sio};
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_rd_byte  = r_mem[r_addr];

    // Only the low ADDR_W bits of the 24b address survive the shift.
    generate
        if (ADDR_W > 4) begin : g_shift_wide
            assign w_addr_shift = {r_addr[ADDR_W-5:0], sqi.i_sqi_sio};
        end else begin : g_shift_narrow
            assign w_addr_shift = sqi.i_sqi_sio[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cmd_hi_nxt = r_cmd_hi;
        w_is_wr_nxt  = r_is_wr;
        w_phase_nxt  = r_phase;
        w_wr_hi_nxt  = r_wr_hi;
        w_addr_nxt   = r_addr;
        w_sio_nxt    = r_sio;
        w_sio_en_nxt = r_sio_en;
        w_mem_we     = 1'b0;
        w_mem_wdata  = {r_wr_hi, sqi.i_sqi_sio};

        if (sqi.i_sqi_cs_n) begin
            // Dropping CS also discards any half-received write byte.
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 3'd0;
            w_phase_nxt  = 1'b0;
            w_sio_nxt    = 4'h0;
            w_sio_en_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = ST_CMD;
                    w_cmd_hi_nxt = sqi.i_sqi_sio;
                    w_cnt_nxt    = 3'd0;
                end
                ST_CMD: begin
                    w_cnt_nxt = 3'd0;
                    if (w_cmd == 8'h03) begin
                        w_state_nxt = ST_ADDR;
                        w_is_wr_nxt = 1'b0;
                    end else if (w_cmd == 8'h02) begin
                        w_state_nxt = ST_ADDR;
                        w_is_wr_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    w_addr_nxt = w_addr_shift;
                    if (r_cnt == 3'd5) begin
                        w_cnt_nxt   = 3'd0;
                        w_phase_nxt = 1'b0;
                        w_state_nxt = r_is_wr ? ST_WR_DATA : ST_DUMMY;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                ST_DUMMY: begin
                    if (r_cnt == 3'd1) begin
                        w_cnt_nxt    = 3'd0;
                        w_state_nxt  = ST_RD_DATA;
                        w_sio_nxt    = w_rd_byte[7:4];
                        w_sio_en_nxt = 1'b1;
                        w_phase_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                ST_RD_DATA: begin
                    w_sio_en_nxt = 1'b1;
                    if (r_phase) begin
                        w_sio_nxt   = w_rd_byte[3:0];
                        w_addr_nxt  = w_addr_inc;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_sio_nxt   = w_rd_byte[7:4];
                        w_phase_nxt = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (r_phase) begin
                        w_mem_we    = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_wr_hi_nxt = sqi.i_sqi_sio;
                        w_phase_nxt = 1'b1;
                    end
                end
                ST_IGNORE: begin
                    w_state_nxt = ST_IGNORE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_cmd_hi <= 4'h0;
            r_is_wr  <= 1'b0;
            r_phase  <= 1'b0;
            r_wr_hi  <= 4'h0;
            r_addr   <= '0;
            r_sio    <= 4'h0;
            r_sio_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cmd_hi <= w_cmd_hi_nxt;
            r_is_wr  <= w_is_wr_nxt;
            r_phase  <= w_phase_nxt;
            r_wr_hi  <= w_wr_hi_nxt;
            r_addr   <= w_addr_nxt;
            r_sio    <= w_sio_nxt;
            r_sio_en <= w_sio_en_nxt;
        end
    end

    // Storage is deliberately not reset; the write is gated by the reset state.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= w_mem_wdata;
        end
    end

    assign sqi.o_sqi_sio    = r_sio;
    assign sqi.o_sqi_sio_en = r_sio_en;

endmodule

// File: tb/tb_idli_sqi_mem_rsp.sv
// Directed bench for the SQI memory responder: writes, reads, wrap, address
// truncation, aborted writes, ignored commands and mid-read reset.
module tb_idli_sqi_mem_rsp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_seen;
    int   n_cmp = 0;
    int   n_bad = 0;

    idli_sqi_mem_rsp_if u_if ();

    idli_sqi_mem_rsp #(.MEM_BYTES(1024)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sqi     (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bus();
        return {3'b000, u_if.o_sqi_sio_en, u_if.o_sqi_sio};
    endfunction

    task automatic step(input logic [3:0] nib);
        u_if.i_sqi_cs_n = 1'b0;
        u_if.i_sqi_sio  = nib;
        @(posedge clk);
        #1;
        en_seen = en_seen | u_if.o_sqi_sio_en;
    endtask

    task automatic cs_hi();
        u_if.i_sqi_cs_n = 1'b1;
        u_if.i_sqi_sio  = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] addr);
        en_seen = 1'b0;
        step(cmd[7:4]);
        step(cmd[3:0]);
        for (int i = 5; i >= 0; i--) step(addr[i*4 +: 4]);
    endtask

    task automatic wr(input string tag, input logic [23:0] addr,
                      input logic [7:0] b0, input logic [7:0] b1, input int nb);
        hdr(8'h02, addr);
        step(b0[7:4]);
        step(b0[3:0]);
        if (nb > 1) begin
            step(b1[7:4]);
            step(b1[3:0]);
        end
        chk({tag, "_en"}, 8'(en_seen), 8'h00);
        cs_hi();
    endtask

    task automatic rd(input string tag, input logic [23:0] addr,
                      input logic [7:0] b0, input logic [7:0] b1, input int nb);
        logic [3:0] exp_n;
        hdr(8'h03, addr);
        step(4'h0);
        chk({tag, "_pre_en"}, 8'(en_seen), 8'h00);
        step(4'h0);
        for (int i = 0; i < nb * 2; i++) begin
            case (i)
                0:       exp_n = b0[7:4];
                1:       exp_n = b0[3:0];
                2:       exp_n = b1[7:4];
                default: exp_n = b1[3:0];
            endcase
            chk($sformatf("%s_nib%0d", tag, i), bus(), {4'h1, exp_n});
            if (i != nb * 2 - 1) step(4'hF);
        end
        cs_hi();
        chk({tag, "_post"}, bus(), 8'h00);
    endtask

    initial begin
        u_if.i_sqi_cs_n = 1'b1;
        u_if.i_sqi_sio  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", bus(), 8'h00);
        rst_n = 1'b1;
        cs_hi();

        // basic write then read
        wr("t1w", 24'h000010, 8'hA5, 8'h3C, 2);
        rd("t1r", 24'h000010, 8'hA5, 8'h3C, 2);

        // streaming across the top of the array
        wr("t2w", 24'h0003FF, 8'h11, 8'h22, 2);
        rd("t2r", 24'h0003FF, 8'h11, 8'h22, 2);
        rd("t2z", 24'h000000, 8'h22, 8'h00, 1);

        // upper address bits are ignored
        rd("t3r", 24'hFFF010, 8'hA5, 8'h3C, 2);
        wr("t3w", 24'hABC020, 8'h66, 8'h00, 1);
        rd("t3c", 24'h000020, 8'h66, 8'h00, 1);

        // half a write byte then CS high leaves memory untouched
        hdr(8'h02, 24'h000020);
        step(4'h7);
        cs_hi();
        rd("t4", 24'h000020, 8'h66, 8'h00, 1);

        // unknown command stays silent and writes nothing
        hdr(8'h9F, 24'h000010);
        for (int i = 0; i < 6; i++) step(4'h5);
        chk("t5_en", 8'(en_seen), 8'h00);
        cs_hi();
        rd("t5", 24'h000010, 8'hA5, 8'h3C, 2);

        // reset during read data clears the bus asynchronously
        hdr(8'h03, 24'h000010);
        step(4'h0);
        step(4'h0);
        chk("t6_nib0", bus(), 8'h1A);
        step(4'h0);
        chk("t6_nib1", bus(), 8'h15);
        rst_n = 1'b0;
        #1;
        chk("t6_rst", bus(), 8'h00);
        u_if.i_sqi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cs_hi();
        rd("t6r", 24'h0003FF, 8'h11, 8'h22, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idli_sqi_mem_rsp.md
Name: idli_sqi_mem_rsp

Overview:
- Synthesisable SQI memory responder: the target end of the core's SQI memory interface.
- Holds one nibble-plane of memory; two instances, SQI_MEM_LO and SQI_MEM_HI, stand in for the external serial RAMs in FPGA builds and benches.
- Decodes 4b-per-cycle command/address/data streams and serves sequential reads and writes from an on-chip byte array.

Parameters:
MEM_BYTES, 1024, bytes of storage; power of two, >= 2.
ADDR_W, $clog2(MEM_BYTES), derived; internal address width.

Ports:
i_clk  input  1  clock; one SQI nibble is transferred per i_clk cycle while selected
i_rst_n  input  1  asynchronous active-low reset
i_sqi_cs_n  input  1  chip select, active low; a transaction runs while low
i_sqi_sio  input  4  nibble from initiator (sqi_data_t)
o_sqi_sio  output  4  nibble to initiator (sqi_data_t), registered
o_sqi_sio_en  output  1  responder drives the bus this cycle, registered

Behaviour:
- Reset: state IDLE, nibble counter 0, address 0, o_sqi_sio=0, o_sqi_sio_en=0. Memory array is not reset.
- Wire format: every byte is sent high nibble first. Command is 2 nibbles. Address is 6 nibbles (24b, MSB first); only the low ADDR_W bits are used, and upper bits are ignored.
- Commands:
  - 0x03 READ: CMD, ADDR, DUMMY (2 nibbles, input ignored), then RD_DATA.
  - 0x02 WRITE: CMD, ADDR, then WR_DATA.
  - Any other value goes to IGNORE.
- States: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
- IDLE -> CMD occurs in the cycle i_sqi_cs_n is sampled low. That cycle's i_sqi_sio is captured as command nibble 0 (the CMD state is entered already holding nibble 0).
- A nibble counter (0..5) tracks position within CMD, ADDR and DUMMY. It resets to 0 on each state change.
- Read timing:
  - In the cycle the 2nd dummy nibble is sampled, the register loads mem[addr][7:4] and sets o_sqi_sio_en=1.
  - The first data nibble is therefore valid in the first RD_DATA cycle.
  - Output then alternates high and low nibble.
  - The address increments when the low nibble is loaded and wraps MEM_BYTES-1 -> 0.
- Write timing:
  - The high nibble is held in a register.
  - On receipt of the low nibble, mem[addr] is written in that same cycle and addr increments with the same wrap.
  - A write then a read of the same byte in a later transaction returns the new value.
- CS deassert (i_sqi_cs_n high) in any state:
  - Next state is IDLE; o_sqi_sio_en=0 and o_sqi_sio=0 on the next edge.
  - A half-received write byte is discarded.
  - A read aborted mid-byte has no side effects.
- IGNORE: no drive and no writes until CS deasserts.
- o_sqi_sio_en is never 1 outside RD_DATA, including the final DUMMY cycle before the register update. This guarantees no bus contention during the address and dummy phases.
- Reset asserted mid-transaction forces IDLE immediately. A write is committed only if its low-nibble edge occurred before reset.
- CS held low with no new command after RD_DATA or WR_DATA continues streaming indefinitely, wrapping around the array.

Test Plan:
1. Write 0x02, addr 0x000010, data 0xA5 0x3C, CS high; then read 0x03, addr 0x000010, 2 dummy nibbles -> o_sqi_sio = A,5,3,C in consecutive cycles with o_sqi_sio_en=1; en=0 in all earlier cycles.
2. MEM_BYTES=1024: write 0x11 at 0x3FF and 0x22 at 0x000 in one streaming transaction starting at 0x3FF; read from 0x3FF for 2 bytes -> 1,1,2,2 (wrap verified).
3. Address 0xFFF010 with MEM_BYTES=1024 -> accesses byte 0x010 (upper bits ignored).
4. Write 0x02 at addr 0x20 with high nibble 0x7 sent, then CS high -> subsequent read of 0x20 returns prior contents unchanged.
5. Command 0x9F, then 12 nibbles with CS low -> o_sqi_sio_en stays 0 and memory is unchanged; next valid READ works normally.
6. Assert i_rst_n=0 during the RD_DATA phase -> o_sqi_sio_en=0 and o_sqi_sio=0 asynchronously. After release, a fresh READ returns correct data.
